uart_tx_drain: RTL

//  Serial UART transmitter that drains a show-ahead FIFO (data valid whenever not empty, pop on read enable).

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_baud_gen.sv | 31 +++
 rtl/uart_tx_drain.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and line levels for the UART transmit path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

  localparam logic UART_IDLE_LVL  = 1'b1;
  localparam logic UART_START_LVL = 1'b0;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: runs 0..div_i and flags the last cycle of every bit period.
module uart_baud_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             restart_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             bit_end_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + DIV_W'(1);
    if (restart_i || (cnt_q == div_i)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_end_o = (cnt_q == div_i);

endmodule

// File: rtl/uart_tx_drain.sv
// UART transmitter draining a show-ahead FIFO; frames go out back-to-back while data remains.
// Optional parity bit after the data bits when UART_TX_PARITY_EN is defined.
module uart_tx_drain
  import uart_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DIV_W     = 16,
  parameter int STOP_BITS = 1
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              en_i,
  input  logic [DIV_W-1:0]  div_i,
  input  logic              parity_odd_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              empty_i,
  output logic              re_o,
  output logic              tx_o,
  output logic              busy_o
);

  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
  localparam logic LAST_STOP = 1'(STOP_BITS - 1);

  uart_tx_state_t    state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [BIT_W-1:0]  bit_idx_q, bit_idx_d;
  logic              stop_idx_q, stop_idx_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              bit_end;
  logic              last_stop;
  logic              restart;

`ifdef UART_TX_PARITY_EN
  logic par_q, par_d;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = parity_odd_i;
`endif

  uart_baud_gen #(
    .DIV_W (DIV_W)
  ) u_baud (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .restart_i (restart),
    .div_i     (div_q),
    .bit_end_o (bit_end)
  );

  assign last_stop = (state_q == STOP) && bit_end && (stop_idx_q == LAST_STOP);
  assign re_o      = rstn_i && en_i && !empty_i && ((state_q == IDLE) || last_stop);
  // Counter is held at zero while idle so the first bit of a frame gets a full period.
  assign restart   = (state_q == IDLE) || re_o;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    div_d      = div_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
`ifdef UART_TX_PARITY_EN
    par_d      = par_q;
`endif

    case (state_q)
      IDLE: ;
      START: begin
        if (bit_end) begin
          state_d   = DATA;
          tx_d      = shift_q[0];
          bit_idx_d = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_d    = PARITY;
            tx_d       = par_q ^ parity_odd_i;
`else
            state_d    = STOP;
            tx_d       = UART_IDLE_LVL;
            stop_idx_d = 1'b0;
`endif
          end else begin
            bit_idx_d = bit_idx_q + BIT_W'(1);
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d    = STOP;
          tx_d       = UART_IDLE_LVL;
          stop_idx_d = 1'b0;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (stop_idx_q == LAST_STOP) begin
            state_d = IDLE;
            tx_d    = UART_IDLE_LVL;
            busy_d  = 1'b0;
          end else begin
            stop_idx_d = stop_idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = UART_IDLE_LVL;
        busy_d  = 1'b0;
      end
    endcase

    // A pop always starts a frame, overriding the stop-state return to idle.
    if (re_o) begin
      state_d = START;
      tx_d    = UART_START_LVL;
      busy_d  = 1'b1;
      shift_d = data_i;
      div_d   = div_i;
`ifdef UART_TX_PARITY_EN
      par_d   = ^data_i;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      div_q      <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      tx_q       <= UART_IDLE_LVL;
      busy_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      div_q      <= div_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
`ifdef UART_TX_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

  assign tx_o   = tx_q;
  assign busy_o = busy_q;

endmodule
